edge_mov_sum: RTL and testbench

EDGE_MOV_SUM -- requirements
Module: edge_mov_sum

---
 rtl/edge_mov_sum.sv | 163 ++++++++++++++++
 tb/tb_edge_mov_sum.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_mov_sum.sv
// rtl/edge_mov_sum.sv - moving-window sum of ADC samples with IDLE/FILL/RUN sequencing
//
// Purpose: keeps the last W valid ADC samples in a circular buffer and emits their
// running sum. W is latched from window_width when a run starts (0 is treated as 1).
// Optional feature macro: EDGE_MOVSUM_PEAK_EN (enables the sum_peak tracker).
//
// Ports:
//   ADC_clk      - single clock, rising edge
//   reset_n      - asynchronous active-low reset, deasserted through a 2-flop synchroniser
//   start        - run enable (level); low returns to IDLE
//   clear        - synchronous core reset, overrides start and ADC_valid
//   window_width - number of samples summed, sampled only on IDLE->FILL
//   ADC_data     - unsigned sample
//   ADC_valid    - ADC_data is valid this cycle
//   sum_out      - registered moving sum, holds between strobes
//   sum_wr       - one-cycle strobe marking a new sum_out
//   filled       - high while in RUN
//   sum_peak     - largest strobed sum since start (0 when the peak feature is off)
module edge_mov_sum #(
  parameter int DATA_W = 10,
  parameter int WIN_W  = 8
) (
  input  logic                      ADC_clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      clear,
  input  logic [WIN_W-1:0]          window_width,
  input  logic [DATA_W-1:0]         ADC_data,
  input  logic                      ADC_valid,
  output logic [DATA_W+WIN_W-1:0]   sum_out,
  output logic                      sum_wr,
  output logic                      filled,
  output logic [DATA_W+WIN_W-1:0]   sum_peak
);

  localparam int SUM_W = DATA_W + WIN_W;
  localparam int DEPTH = 1 << WIN_W;
  localparam logic [WIN_W-1:0] ONE_W = {{(WIN_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t            state, state_nxt;
  logic [WIN_W-1:0]  w_len, w_nxt;
  logic [WIN_W-1:0]  wr_ptr, ptr_nxt, ptr_adv;
  logic [WIN_W-1:0]  fill_cnt, cnt_nxt;
  logic [SUM_W-1:0]  acc, acc_nxt, acc_add;
  logic [SUM_W-1:0]  sum_nxt;
  logic              wr_nxt;
  logic              buf_we;
  logic [DATA_W-1:0] old_sample;
  logic [DATA_W-1:0] buf_mem [DEPTH];

  // Reset asserts immediately but releases two clocks later, so every flop
  // below leaves reset on a clean edge.
  logic [1:0] rst_sync;
  logic       rst_n_int;

  always_ff @(posedge ADC_clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n_int = rst_sync[1];

  // Sample store: no reset needed, FILL overwrites every slot RUN will read.
  always_ff @(posedge ADC_clk) begin
    if (buf_we) buf_mem[wr_ptr] <= ADC_data;
  end

  assign old_sample = buf_mem[wr_ptr];
  assign ptr_adv    = (wr_ptr == w_len - ONE_W) ? '0 : wr_ptr + ONE_W;
  assign acc_add    = acc + SUM_W'(ADC_data);

  always_comb begin
    state_nxt = state;
    w_nxt     = w_len;
    ptr_nxt   = wr_ptr;
    cnt_nxt   = fill_cnt;
    acc_nxt   = acc;
    sum_nxt   = sum_out;
    wr_nxt    = 1'b0;
    buf_we    = 1'b0;
    if (clear || !start) begin
      state_nxt = IDLE;
      ptr_nxt   = '0;
      cnt_nxt   = '0;
      acc_nxt   = '0;
      sum_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = FILL;
          w_nxt     = (window_width == '0) ? ONE_W : window_width;
          ptr_nxt   = '0;
          cnt_nxt   = '0;
          acc_nxt   = '0;
        end
        FILL: begin
          if (ADC_valid) begin
            buf_we  = 1'b1;
            ptr_nxt = ptr_adv;
            acc_nxt = acc_add;
            cnt_nxt = fill_cnt + ONE_W;
            if (fill_cnt + ONE_W == w_len) begin
              state_nxt = RUN;
              sum_nxt   = acc_add;
              wr_nxt    = 1'b1;
            end
          end
        end
        RUN: begin
          if (ADC_valid) begin
            buf_we  = 1'b1;
            ptr_nxt = ptr_adv;
            // old_sample is already part of acc, so this never goes negative.
            acc_nxt = acc_add - SUM_W'(old_sample);
            sum_nxt = acc_add - SUM_W'(old_sample);
            wr_nxt  = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge ADC_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state    <= IDLE;
      w_len    <= ONE_W;
      wr_ptr   <= '0;
      fill_cnt <= '0;
      acc      <= '0;
      sum_out  <= '0;
      sum_wr   <= 1'b0;
    end else begin
      state    <= state_nxt;
      w_len    <= w_nxt;
      wr_ptr   <= ptr_nxt;
      fill_cnt <= cnt_nxt;
      acc      <= acc_nxt;
      sum_out  <= sum_nxt;
      sum_wr   <= wr_nxt;
    end
  end

  assign filled = (state == RUN);

`ifdef EDGE_MOVSUM_PEAK_EN
  logic [SUM_W-1:0] peak_r;

  // Tracks the registered strobe, so the peak lags sum_out by one cycle.
  always_ff @(posedge ADC_clk or negedge rst_n_int) begin
    if (!rst_n_int)                        peak_r <= '0;
    else if (clear || !start)              peak_r <= '0;
    else if (sum_wr && (sum_out > peak_r)) peak_r <= sum_out;
  end

  assign sum_peak = peak_r;
`else
  assign sum_peak = '0;
`endif

endmodule

// File: tb/tb_edge_mov_sum.sv
// tb/tb_edge_mov_sum.sv - randomized self-checking bench for edge_mov_sum against a queue model
module tb_edge_mov_sum;
  localparam int DATA_W = 10;
  localparam int WIN_W  = 8;
  localparam int SUM_W  = DATA_W + WIN_W;

  logic              ADC_clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              clear = 1'b0;
  logic              ADC_valid = 1'b0;
  logic [WIN_W-1:0]  window_width = '0;
  logic [DATA_W-1:0] ADC_data = '0;
  logic [SUM_W-1:0]  sum_out;
  logic [SUM_W-1:0]  sum_peak;
  logic              sum_wr;
  logic              filled;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 ADC_clk = ~ADC_clk;

  edge_mov_sum #(.DATA_W(DATA_W), .WIN_W(WIN_W)) dut (
    .ADC_clk      (ADC_clk),
    .reset_n      (reset_n),
    .start        (start),
    .clear        (clear),
    .window_width (window_width),
    .ADC_data     (ADC_data),
    .ADC_valid    (ADC_valid),
    .sum_out      (sum_out),
    .sum_wr       (sum_wr),
    .filled       (filled),
    .sum_peak     (sum_peak)
  );

  // Reference: a run holds the accepted samples in a queue; once it holds W
  // samples every new sample yields the plain sum of the last W.
  bit     m_active;
  int     m_w;
  int     m_q[$];
  longint m_sum;
  bit     m_wr;
  bit     m_filled;
  longint m_peak;
  longint strobes[$];

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_w      = 1;
    m_q.delete();
    m_sum    = 0;
    m_wr     = 1'b0;
    m_filled = 1'b0;
    m_peak   = 0;
  endtask

  task automatic model_step(input bit st, input bit cl, input int ww, input int d, input bit v);
    longint s;
    if (cl || !st) begin
      model_reset();
      return;
    end
`ifdef EDGE_MOVSUM_PEAK_EN
    if (m_wr && m_sum > m_peak) m_peak = m_sum;
`endif
    m_wr = 1'b0;
    if (!m_active) begin
      m_active = 1'b1;
      m_w = (ww == 0) ? 1 : ww;
      m_q.delete();
      return;
    end
    if (v) begin
      m_q.push_back(d);
      if (m_q.size() > m_w) void'(m_q.pop_front());
      if (m_q.size() == m_w) begin
        s = 0;
        foreach (m_q[k]) s += m_q[k];
        m_sum    = s;
        m_wr     = 1'b1;
        m_filled = 1'b1;
      end
    end
  endtask

  // One clock: compare the outputs of the last edge, then drive the next inputs.
  task automatic tick(input bit st, input bit cl, input int ww, input int d, input bit v);
    @(negedge ADC_clk);
    check_eq("sum_wr", sum_wr, m_wr);
    check_eq("sum_out", sum_out, m_sum);
    check_eq("filled", filled, m_filled);
    check_eq("sum_peak", sum_peak, m_peak);
    if (sum_wr) strobes.push_back(sum_out);
    start        = st;
    clear        = cl;
    window_width = ww[WIN_W-1:0];
    ADC_data     = d[DATA_W-1:0];
    ADC_valid    = v;
    model_step(st, cl, ww, d, v);
  endtask

  task automatic check_list(input string tag, input int n, input longint a, input longint b, input longint c);
    check_eq($sformatf("%s_count", tag), strobes.size(), n);
    if (n > 0 && strobes.size() > 0) check_eq($sformatf("%s_s0", tag), strobes[0], a);
    if (n > 1 && strobes.size() > 1) check_eq($sformatf("%s_s1", tag), strobes[1], b);
    if (n > 2 && strobes.size() > 2) check_eq($sformatf("%s_s2", tag), strobes[2], c);
  endtask

  task automatic do_reset(input string tag);
    @(negedge ADC_clk);
    reset_n   = 1'b0;
    start     = 1'b0;
    clear     = 1'b0;
    ADC_valid = 1'b0;
    #1;
    check_eq($sformatf("%s_sum_out", tag), sum_out, 0);
    check_eq($sformatf("%s_sum_wr", tag), sum_wr, 0);
    check_eq($sformatf("%s_filled", tag), filled, 0);
    check_eq($sformatf("%s_sum_peak", tag), sum_peak, 0);
    model_reset();
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    reset_n = 1'b1;
    repeat (3) tick(0, 0, 0, 0, 0);
  endtask

  bit r_st, r_cl, r_v;
  int r_ww, r_d;

  initial begin
    model_reset();
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    reset_n = 1'b1;
    repeat (3) tick(0, 0, 0, 0, 0);

    // W=4, data 1..6 every cycle
    strobes.delete();
    tick(1, 0, 4, 0, 0);
    for (int i = 1; i <= 6; i++) tick(1, 0, 4, i, 1);
    tick(1, 0, 4, 0, 0);
    tick(1, 0, 4, 0, 0);
    check_list("w4_dense", 3, 10, 14, 18);
    tick(0, 0, 0, 0, 0);

    // W=0 behaves as W=1
    strobes.delete();
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 7, 1);
    tick(1, 0, 0, 9, 1);
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    check_list("w0", 2, 7, 9, 0);
    tick(0, 0, 0, 0, 0);

    // W=255 full scale, then zeros exercise the pointer wrap
    strobes.delete();
    tick(1, 0, 255, 0, 0);
    repeat (255) tick(1, 0, 255, 1023, 1);
    tick(1, 0, 255, 0, 1);
    tick(1, 0, 255, 0, 1);
    tick(1, 0, 255, 0, 0);
    tick(1, 0, 255, 0, 0);
    check_list("w255", 3, 260865, 259842, 258819);
    tick(0, 0, 0, 0, 0);

    // W=4 with valid gaps
    strobes.delete();
    tick(1, 0, 4, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      tick(1, 0, 4, i, 1);
      tick(1, 0, 4, 99, 0);
    end
    tick(1, 0, 4, 0, 0);
    check_list("w4_gaps", 3, 10, 14, 18);

    // Restart mid-RUN with a new width: no stale samples
    tick(0, 0, 0, 0, 0);
    tick(1, 0, 3, 0, 0);
    repeat (4) tick(1, 0, 3, 5, 1);
    tick(0, 0, 3, 0, 0);
    strobes.delete();
    tick(1, 0, 2, 0, 0);
    tick(1, 0, 2, 3, 1);
    tick(1, 0, 2, 3, 1);
    tick(1, 0, 2, 0, 0);
    tick(1, 0, 2, 0, 0);
    check_list("restart", 1, 6, 0, 0);

    // clear wins over start and valid
    tick(1, 0, 2, 8, 1);
    tick(1, 1, 2, 7, 1);
    tick(1, 0, 2, 0, 0);
    tick(1, 0, 2, 4, 1);
    tick(1, 0, 2, 4, 1);
    tick(0, 0, 0, 0, 0);

    // Peak at W=1, data 5,1,1
    tick(1, 0, 1, 0, 0);
    tick(1, 0, 1, 5, 1);
    tick(1, 0, 1, 1, 1);
    tick(1, 0, 1, 1, 1);
    tick(1, 0, 1, 0, 0);
    tick(1, 0, 1, 0, 0);
    @(negedge ADC_clk);
`ifdef EDGE_MOVSUM_PEAK_EN
    check_eq("peak_w1", sum_peak, 5);
`else
    check_eq("peak_w1", sum_peak, 0);
`endif

    // Reset asserted mid-RUN and mid-FILL
    do_reset("rst_run_pre");
    tick(1, 0, 3, 0, 0);
    repeat (5) tick(1, 0, 3, 200, 1);
    do_reset("rst_run");
    tick(1, 0, 8, 0, 0);
    repeat (3) tick(1, 0, 8, 11, 1);
    do_reset("rst_fill");

    for (int i = 0; i < 3000; i++) begin
      r_st = ($urandom_range(0, 63) != 0);
      r_cl = ($urandom_range(0, 99) == 0);
      r_ww = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
      r_d  = ($urandom_range(0, 3) == 0) ? 1023 : int'($urandom_range(0, 1023));
      r_v  = ($urandom_range(0, 9) < 7);
      tick(r_st, r_cl, r_ww, r_d, r_v);
    end
    tick(0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
